// File: rtl/input_buffer_llr_writer.sv
// Packs per-symbol LLR beats into 16-lane words for the input buffer.
// Optional build macro IBW_LLR_SYM_CLIP_EN clips -32 LLRs to -31.
module input_buffer_llr_writer (
    input  logic         i_core_clk,
    input  logic         i_rx_rst,
    input  logic         i_rx_fsm_rst,
    input  logic         i_start,
    input  logic [13:0]  i_e01_size,
    input  logic [3:0]   i_qm,
    input  logic         i_llr_valid,
    input  logic [47:0]  i_llr_data,
    output logic         o_llr_ready,
    output logic         o_wr_en,
    output logic [15:0]  o_wr_addr,
    output logic [767:0] o_wr_data,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t         state_q;
    logic [13:0]    e01_q;
    logic [13:0]    sym_q;
    logic [3:0]     qm_q;
    logic           last_q;
    logic [767:0]   acc_q;
    logic           wr_en_q;
    logic [15:0]    wr_addr_q;
    logic [767:0]   wr_data_q;
    logic           done_q;
    logic           err_q;

    logic           rst;
    logic           accept;
    logic           word_end;
    logic           qm_bad;
    logic [47:0]    lane_d;
    logic [767:0]   word_d;

    function automatic logic [5:0] llr_fix(input logic [5:0] v);
`ifdef IBW_LLR_SYM_CLIP_EN
        return (v == 6'h20) ? 6'h21 : v;
`else
        return v;
`endif
    endfunction

    assign rst      = i_rx_rst | i_rx_fsm_rst;
    // Ready drops once the last beat is in, while the final write drains.
    assign o_llr_ready = (state_q == FILL) && !last_q;
    assign accept   = i_llr_valid && o_llr_ready;
    assign word_end = (sym_q[3:0] == 4'hF) || (sym_q == e01_q);
    assign qm_bad   = (i_qm == 4'd0) || (i_qm > 4'd8);

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;
    assign o_err     = err_q;

    // Format the incoming beat and merge it into the current word image.
    always_comb begin
        lane_d = '0;
        for (int j = 0; j < 8; j++) begin
            if (4'(j) < qm_q) begin
                lane_d[6*j +: 6] = llr_fix(i_llr_data[6*j +: 6]);
            end
        end
        word_d = acc_q;
        word_d[48*int'(sym_q[3:0]) +: 48] = lane_d;
    end

    // Control FSM with accumulator and registered write/status outputs.
    always_ff @(posedge i_core_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            e01_q     <= '0;
            sym_q     <= '0;
            qm_q      <= '0;
            last_q    <= 1'b0;
            acc_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        e01_q  <= i_e01_size;
                        qm_q   <= i_qm;
                        sym_q  <= '0;
                        last_q <= 1'b0;
                        acc_q  <= '0;
                        if (qm_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        last_q  <= 1'b0;
                    end else if (accept) begin
                        sym_q <= sym_q + 14'd1;
                        if (word_end) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {6'd0, sym_q[13:4]};
                            wr_data_q <= word_d;
                            acc_q     <= '0;
                            last_q    <= (sym_q == e01_q);
                        end else begin
                            acc_q <= word_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer_llr_writer.sv
// Directed bench for input_buffer_llr_writer.
// Scenario tasks run in sequence from one initial block.
module tb_input_buffer_llr_writer;

    logic         clk = 1'b0;
    logic         i_rx_rst = 1'b0;
    logic         i_rx_fsm_rst = 1'b0;
    logic         i_start = 1'b0;
    logic [13:0]  i_e01_size = '0;
    logic [3:0]   i_qm = '0;
    logic         i_llr_valid = 1'b0;
    logic [47:0]  i_llr_data = '0;
    logic         o_llr_ready;
    logic         o_wr_en;
    logic [15:0]  o_wr_addr;
    logic [767:0] o_wr_data;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    input_buffer_llr_writer dut (
        .i_core_clk   (clk),
        .i_rx_rst     (i_rx_rst),
        .i_rx_fsm_rst (i_rx_fsm_rst),
        .i_start      (i_start),
        .i_e01_size   (i_e01_size),
        .i_qm         (i_qm),
        .i_llr_valid  (i_llr_valid),
        .i_llr_data   (i_llr_data),
        .o_llr_ready  (o_llr_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  addr;
        logic [767:0] data;
        int           cyc;
    } wr_t;

    int   cyc = 0;
    wr_t  wr_log[$];
    int   done_cyc[$];
    int   err_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (o_wr_en === 1'b1) begin
            e.addr = o_wr_addr;
            e.data = o_wr_data;
            e.cyc  = cyc;
            wr_log.push_back(e);
        end
        if (o_done === 1'b1) done_cyc.push_back(cyc);
        if (o_err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] beat(input int kind, input int n);
        logic [47:0] b;
        case (kind)
            0:       b = {{6{6'h3F}}, 6'(n + 32), 6'(n)};
            1:       b = {8{6'h15}};
            2:       b = {8{6'h20}};
            default: b = {{6{6'h2A}}, 6'(n + 40), 6'(n + 5)};
        endcase
        return b;
    endfunction

    task automatic start_block(input logic [13:0] e01, input logic [3:0] qm);
        i_e01_size = e01;
        i_qm       = qm;
        i_start    = 1'b1;
        step();
        i_start    = 1'b0;
    endtask

    task automatic send_beats(input int kind, input int first, input int last,
                              input bit gaps, output int acc15, output int acc_last);
        acc15    = -1;
        acc_last = -1;
        for (int n = first; n <= last; n++) begin
            if (gaps) begin
                i_llr_valid = 1'b0;
                i_llr_data  = 48'hFFFF_FFFF_FFFF;
                step();
            end
            i_llr_valid = 1'b1;
            i_llr_data  = beat(kind, n);
            total++;
            if (o_llr_ready !== 1'b1) begin
                bad++;
                $display("FAIL ready_beat%0d got=%b want=1", n, o_llr_ready);
            end
            step();
            if (n == 15) acc15 = cyc;
            acc_last = cyc;
        end
        i_llr_valid = 1'b0;
        i_llr_data  = '0;
    endtask

    task automatic test_reset();
        i_rx_rst = 1'b1;
        step();
        i_rx_rst = 1'b0;
        total += 7;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        if (o_llr_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", o_llr_ready); end
        if (o_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b want=0", o_wr_en); end
        if (o_wr_addr !== 16'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", o_wr_addr); end
        if (o_wr_data !== 768'd0) begin bad++; $display("FAIL rst_data got=nonzero want=0"); end
        if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", o_done); end
        if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", o_err); end
        step();
    endtask

    task automatic test_qm2();
        logic [767:0] exp;
        int a15, al;
        wr_log.delete();
        exp = '0;
        for (int i = 0; i < 16; i++) exp[i*48 +: 48] = {36'd0, 6'(i + 32), 6'(i)};
        start_block(14'd15, 4'd2);
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL qm2_busy got=%b want=1", o_busy); end
        send_beats(0, 0, 15, 1'b0, a15, al);
        total += 4;
        if (o_wr_en !== 1'b1) begin bad++; $display("FAIL qm2_wr_en got=%b want=1", o_wr_en); end
        if (o_llr_ready !== 1'b0) begin bad++; $display("FAIL qm2_ready_drop got=%b want=0", o_llr_ready); end
        if (o_wr_addr !== 16'd0) begin bad++; $display("FAIL qm2_addr got=%h want=0", o_wr_addr); end
        if (o_wr_data !== exp) begin bad++; $display("FAIL qm2_data got=%h want=%h", o_wr_data[95:0], exp[95:0]); end
        step();
        total += 3;
        if (o_done !== 1'b1) begin bad++; $display("FAIL qm2_done got=%b want=1", o_done); end
        if (o_wr_en !== 1'b0) begin bad++; $display("FAIL qm2_wr_en_off got=%b want=0", o_wr_en); end
        if (o_err !== 1'b0) begin bad++; $display("FAIL qm2_err got=%b want=0", o_err); end
        step();
        total += 3;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL qm2_idle got=%b want=0", o_busy); end
        if (o_done !== 1'b0) begin bad++; $display("FAIL qm2_done_off got=%b want=0", o_done); end
        if (wr_log.size() != 1) begin bad++; $display("FAIL qm2_nwrites got=%0d want=1", wr_log.size()); end
    endtask

    task automatic test_qm8(input bit gaps);
        logic [767:0] w0, w1;
        int a15, al, e0;
        wr_log.delete();
        done_cyc.delete();
        e0 = err_cnt;
        w0 = {16{{8{6'h15}}}};
        w1 = '0;
        for (int i = 0; i < 5; i++) w1[i*48 +: 48] = {8{6'h15}};
        start_block(14'd20, 4'd8);
        if (gaps) begin
            i_start = 1'b1;
            i_qm    = 4'd0;
        end
        send_beats(1, 0, 20, gaps, a15, al);
        i_start = 1'b0;
        step();
        step();
        total++;
        if (wr_log.size() != 2) begin
            bad++;
            $display("FAIL qm8_nwrites gaps=%0d got=%0d want=2", gaps, wr_log.size());
        end else begin
            total += 6;
            if (wr_log[0].addr !== 16'd0) begin bad++; $display("FAIL qm8_addr0 got=%h want=0", wr_log[0].addr); end
            if (wr_log[0].data !== w0) begin bad++; $display("FAIL qm8_data0 got=%h want=%h", wr_log[0].data[95:0], w0[95:0]); end
            if (wr_log[0].cyc !== a15) begin bad++; $display("FAIL qm8_when0 got=%0d want=%0d", wr_log[0].cyc, a15); end
            if (wr_log[1].addr !== 16'd1) begin bad++; $display("FAIL qm8_addr1 got=%h want=1", wr_log[1].addr); end
            if (wr_log[1].data !== w1) begin bad++; $display("FAIL qm8_data1 got=%h want=%h", wr_log[1].data[287:192], w1[287:192]); end
            if (wr_log[1].cyc !== al) begin bad++; $display("FAIL qm8_when1 got=%0d want=%0d", wr_log[1].cyc, al); end
        end
        total += 4;
        if (done_cyc.size() != 1 || done_cyc[0] != al + 1) begin
            bad++;
            $display("FAIL qm8_done_cycle n=%0d want_cycle=%0d", done_cyc.size(), al + 1);
        end
        if (err_cnt != e0) begin bad++; $display("FAIL qm8_err got=%0d want=%0d", err_cnt, e0); end
        if (o_wr_addr !== 16'd1) begin bad++; $display("FAIL qm8_hold_addr got=%h want=1", o_wr_addr); end
        if (o_wr_data !== w1) begin bad++; $display("FAIL qm8_hold_data got=%h want=%h", o_wr_data[287:192], w1[287:192]); end
    endtask

    task automatic test_bad_qm();
        logic [3:0] qv[3];
        qv[0] = 4'd0;
        qv[1] = 4'd9;
        qv[2] = 4'd15;
        wr_log.delete();
        for (int k = 0; k < 3; k++) begin
            start_block(14'd5, qv[k]);
            total += 4;
            if (o_done !== 1'b1) begin bad++; $display("FAIL badqm%0d_done got=%b want=1", qv[k], o_done); end
            if (o_err !== 1'b1) begin bad++; $display("FAIL badqm%0d_err got=%b want=1", qv[k], o_err); end
            if (o_llr_ready !== 1'b0) begin bad++; $display("FAIL badqm%0d_ready got=%b want=0", qv[k], o_llr_ready); end
            if (o_wr_en !== 1'b0) begin bad++; $display("FAIL badqm%0d_wr got=%b want=0", qv[k], o_wr_en); end
            step();
            total += 3;
            if (o_done !== 1'b0) begin bad++; $display("FAIL badqm%0d_done_off got=%b want=0", qv[k], o_done); end
            if (o_err !== 1'b0) begin bad++; $display("FAIL badqm%0d_err_off got=%b want=0", qv[k], o_err); end
            if (o_busy !== 1'b0) begin bad++; $display("FAIL badqm%0d_idle got=%b want=0", qv[k], o_busy); end
        end
        total++;
        if (wr_log.size() != 0) begin bad++; $display("FAIL badqm_nwrites got=%0d want=0", wr_log.size()); end
    endtask

    task automatic test_fsm_rst();
        logic [767:0] exp;
        int a15, al;
        wr_log.delete();
        exp = '0;
        for (int i = 0; i < 16; i++) exp[i*48 +: 48] = {36'd0, 6'(i + 40), 6'(i + 5)};
        start_block(14'd15, 4'd2);
        send_beats(0, 0, 9, 1'b0, a15, al);
        i_rx_fsm_rst = 1'b1;
        i_llr_valid  = 1'b1;
        i_llr_data   = beat(0, 10);
        step();
        i_rx_fsm_rst = 1'b0;
        i_llr_valid  = 1'b0;
        total += 4;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL frst_idle got=%b want=0", o_busy); end
        if (o_llr_ready !== 1'b0) begin bad++; $display("FAIL frst_ready got=%b want=0", o_llr_ready); end
        if (o_wr_en !== 1'b0) begin bad++; $display("FAIL frst_wr got=%b want=0", o_wr_en); end
        if (o_wr_data !== 768'd0) begin bad++; $display("FAIL frst_data got=nonzero want=0"); end
        step();
        step();
        total++;
        if (wr_log.size() != 0) begin bad++; $display("FAIL frst_nwrites got=%0d want=0", wr_log.size()); end
        start_block(14'd15, 4'd2);
        send_beats(3, 0, 15, 1'b0, a15, al);
        total += 3;
        if (o_wr_en !== 1'b1) begin bad++; $display("FAIL frst2_wr got=%b want=1", o_wr_en); end
        if (o_wr_addr !== 16'd0) begin bad++; $display("FAIL frst2_addr got=%h want=0", o_wr_addr); end
        if (o_wr_data !== exp) begin bad++; $display("FAIL frst2_data got=%h want=%h", o_wr_data[95:0], exp[95:0]); end
        step();
        total++;
        if (o_done !== 1'b1) begin bad++; $display("FAIL frst2_done got=%b want=1", o_done); end
        step();
    endtask

    task automatic test_clip();
        logic [767:0] exp;
        int a15, al;
        exp = '0;
`ifdef IBW_LLR_SYM_CLIP_EN
        exp[5:0] = 6'h21;
`else
        exp[5:0] = 6'h20;
`endif
        start_block(14'd0, 4'd1);
        send_beats(2, 0, 0, 1'b0, a15, al);
        total += 3;
        if (o_wr_en !== 1'b1) begin bad++; $display("FAIL clip_wr got=%b want=1", o_wr_en); end
        if (o_wr_addr !== 16'd0) begin bad++; $display("FAIL clip_addr got=%h want=0", o_wr_addr); end
        if (o_wr_data !== exp) begin bad++; $display("FAIL clip_data got=%h want=%h", o_wr_data[47:0], exp[47:0]); end
        step();
        total++;
        if (o_done !== 1'b1) begin bad++; $display("FAIL clip_done got=%b want=1", o_done); end
        step();
    endtask

    initial begin
        test_reset();
        test_qm2();
        test_qm8(1'b0);
        test_qm8(1'b1);
        test_bad_qm();
        test_fsm_rst();
        test_clip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_buffer_llr_writer.md
INPUT_BUFFER_LLR_WRITER -- requirements
Module: input_buffer_llr_writer

Interface
REQ-001 SHALL have port i_core_clk, input, 1: the single clock; all logic samples on its rising edge.
REQ-002 SHALL have port i_rx_rst, input, 1: synchronous active-high reset, the global reset.
REQ-003 SHALL have port i_rx_fsm_rst, input, 1: synchronous active-high reset that returns the FSM to its initial state; same effect as i_rx_rst.
REQ-004 SHALL have port i_start, input, 1: one-cycle request to begin a code block; sampled in IDLE only.
REQ-005 SHALL have port i_e01_size, input, 14: per-layer LLR count minus 1 (last symbol index); sampled with i_start.
REQ-006 SHALL have port i_qm, input, 4: modulation order 1..8 (LLRs per symbol); sampled with i_start.
REQ-007 SHALL have port i_llr_valid, input, 1: a symbol beat is present.
REQ-008 SHALL have port i_llr_data, input, 48: layer j LLR in bits [6j+5:6j]; bits for j>=qm are ignored.
REQ-009 SHALL have port o_llr_ready, output, 1: the beat is accepted when i_llr_valid and o_llr_ready are both 1.
REQ-010 SHALL have port o_wr_en, output, 1: one-cycle write strobe to the input buffer.
REQ-011 SHALL have port o_wr_addr, output, 16: word offset address, zero-extended.
REQ-012 SHALL have port o_wr_data, output, 768: lane i (0..15), layer j (0..7) occupies bits [i*48+6j+5 : i*48+6j].
REQ-013 SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port o_err, output, 1: one-cycle pulse when i_qm is illegal; asserted together with o_done.

Function
REQ-016 SHALL implement states IDLE, FILL, DONE.
- IDLE -> FILL on i_start=1 with 1<=i_qm<=8.
- IDLE -> DONE on i_start=1 with i_qm=0 or i_qm>8; o_err pulses.
- FILL -> DONE after the beat for symbol index == latched e01 is accepted.
- DONE -> IDLE unconditionally.
REQ-017 SHALL drive o_llr_ready=1 only in FILL, and SHALL drop it combinationally in the cycle after the last beat is accepted.
REQ-018 SHALL place symbol n at word n[13:4], lane n[3:0]; layers j<qm come from i_llr_data, layers j>=qm are written as 0.
REQ-019 SHALL capture the word into o_wr_data and pulse o_wr_en one cycle after the accepting edge of lane 15 or of the last symbol; o_wr_addr equals that word index.
REQ-020 SHALL write 0 in the lanes of the final partial word above e01[3:0].
REQ-021 SHALL sustain one beat per cycle with no bubble at word boundaries: the accumulator clears and loads lane 0 of the next word on the same edge as the write capture.
REQ-022 SHALL ignore gaps in i_llr_valid (no state change) and SHALL drop beats presented while o_llr_ready=0.
REQ-023 SHALL assert o_done in the DONE cycle, which is the cycle after the final o_wr_en.
REQ-024 SHALL ignore i_start outside IDLE.
REQ-025 SHALL start each code block at o_wr_addr=0.
REQ-026 SHALL hold o_wr_addr and o_wr_data between strobes.

Reset
REQ-027 SHALL, on i_rx_rst or i_rx_fsm_rst at a rising edge, enter IDLE and drive 0 on all outputs and counters, with the accumulator cleared.
REQ-028 SHALL discard a partially filled word on reset mid-block, with no write.
REQ-029 SHALL let reset take priority over a simultaneous i_start or accepted beat.

Configuration
REQ-030 SHALL honour macro IBW_LLR_SYM_CLIP_EN.
- Defined: each accepted LLR equal to 6'h20 (-32) is stored as 6'h21 (-31), giving symmetric range.
- Undefined: LLRs are stored unmodified.
- Timing and latency are identical in both builds.

Verification
REQ-031 SHALL cover: qm=2, e01=15, symbol n layer0=n, layer1=n+32 -> one write at addr 0; lane i holds i / i+32 in layers 0/1, other layers 0; o_done next cycle.
REQ-032 SHALL cover: qm=8, e01=20, all LLRs 6'h15 -> addr 0 full of 6'h15; addr 1 has lanes 0-4 set and lanes 5-15 zero; o_done after the second write.
REQ-033 SHALL cover: scenario REQ-032 with i_llr_valid toggled every other cycle -> identical writes; o_wr_en only after lane 15 and after the last symbol.
REQ-034 SHALL cover: i_start with i_qm=0 -> o_done and o_err pulse one cycle later, no o_wr_en, o_llr_ready stays 0.
REQ-035 SHALL cover: i_rx_fsm_rst pulsed after 10 of 16 beats -> no write, IDLE next cycle; a new i_start writes fresh from addr 0.
REQ-036 SHALL cover: LLR 6'h20 with qm=1, e01=0 -> written as 6'h21 with IBW_LLR_SYM_CLIP_EN defined, 6'h20 without.
